// File: rtl/gpio_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_arb_pkg
//  Description : Shared types and constants for the GPIO header arbiter.
//                - arb_state_t : arbiter FSM encoding
//                - ADDR_*      : register select (requester addr[0])
//                - HDR_*       : header select   (requester addr[1])
//  Revision    : 1.0 - initial release
// ============================================================================
package gpio_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_ACK   = 2'd2,
        ST_HOLD  = 2'd3
    } arb_state_t;

    localparam logic ADDR_DATA = 1'b0;
    localparam logic ADDR_DIR  = 1'b1;
    localparam logic HDR_0     = 1'b0;
    localparam logic HDR_1     = 1'b1;

endpackage : gpio_arb_pkg
`default_nettype wire

// File: rtl/gpio_in_sync.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_in_sync
//  Description : Two-flop synchroniser bank for asynchronous header pins.
//  Ports       : clk      - system clock
//                reset_n  - asynchronous active-low reset
//                i_async  - raw pin inputs (WIDTH bits)
//                o_sync   - synchronised pins, two clk cycles behind i_async
//  Revision    : 1.0 - initial release
// ============================================================================
module gpio_in_sync #(
    parameter int WIDTH = 36
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule : gpio_in_sync
`default_nettype wire

// File: rtl/gpio_header_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_header_arbiter
//  Description : Round-robin arbiter giving two requesters (r0 = HPS bridge,
//                r1 = FPGA engine) access to the data/direction registers and
//                synchronised inputs of two GPIO headers. A requester may
//                lock the grant across several accesses; a watchdog releases
//                a lock that idles for LOCK_TIMEOUT cycles.
//  Ports       : clk, reset_n              - clock, async active-low reset
//                i_rN_req/lock/we/addr/wdata - requester N access (N = 0,1)
//                o_rN_ack/rdata            - one-cycle completion, read data
//                i_gpioM_in                - raw header pins (M = 0,1)
//                o_gpioM_out/oe            - output value / output enable
//                o_owner                   - {valid, id} of current grant
//                o_lock_err                - pulse on watchdog release
//  Revision    : 1.0 - initial release
// ============================================================================
module gpio_header_arbiter
    import gpio_arb_pkg::*;
#(
    parameter int GPIO_W       = 36,
    parameter int LOCK_TIMEOUT = 1024,
    parameter int CNT_W        = 11
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              i_r0_req,
    input  logic              i_r0_lock,
    input  logic              i_r0_we,
    input  logic [1:0]        i_r0_addr,
    input  logic [GPIO_W-1:0] i_r0_wdata,
    output logic              o_r0_ack,
    output logic [GPIO_W-1:0] o_r0_rdata,

    input  logic              i_r1_req,
    input  logic              i_r1_lock,
    input  logic              i_r1_we,
    input  logic [1:0]        i_r1_addr,
    input  logic [GPIO_W-1:0] i_r1_wdata,
    output logic              o_r1_ack,
    output logic [GPIO_W-1:0] o_r1_rdata,

    input  logic [GPIO_W-1:0] i_gpio0_in,
    output logic [GPIO_W-1:0] o_gpio0_out,
    output logic [GPIO_W-1:0] o_gpio0_oe,
    input  logic [GPIO_W-1:0] i_gpio1_in,
    output logic [GPIO_W-1:0] o_gpio1_out,
    output logic [GPIO_W-1:0] o_gpio1_oe,

    output logic [1:0]        o_owner,
    output logic              o_lock_err
);

    // Watchdog fires on the HOLD cycle where the idle count reaches this value.
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

    arb_state_t        r_state;
    logic              r_owner_vld;
    logic              r_owner_id;
    logic              r_last_grant;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_lock_err;
    logic [1:0]        r_ack;
    logic [GPIO_W-1:0] r_rdata [2];
    logic [GPIO_W-1:0] r_out   [2];
    logic [GPIO_W-1:0] r_oe    [2];

    logic [GPIO_W-1:0] w_gpio_in [2];
    logic [GPIO_W-1:0] w_sync    [2];

    // ------------------------------------------------------------------
    // Input synchronisers, one per header
    // ------------------------------------------------------------------
    assign w_gpio_in[HDR_0] = i_gpio0_in;
    assign w_gpio_in[HDR_1] = i_gpio1_in;

    for (genvar h = 0; h < 2; h++) begin : g_sync
        gpio_in_sync #(
            .WIDTH (GPIO_W)
        ) u_sync (
            .clk     (clk),
            .reset_n (reset_n),
            .i_async (w_gpio_in[h]),
            .o_sync  (w_sync[h])
        );
    end

    // ------------------------------------------------------------------
    // Current owner's request view
    // ------------------------------------------------------------------
    logic              w_sel_req;
    logic              w_sel_lock;
    logic              w_sel_we;
    logic [1:0]        w_sel_addr;
    logic [GPIO_W-1:0] w_sel_wdata;
    logic [GPIO_W-1:0] w_rd_val;
    logic              w_any_req;
    logic              w_grant_id;

    assign w_sel_req   = r_owner_id ? i_r1_req   : i_r0_req;
    assign w_sel_lock  = r_owner_id ? i_r1_lock  : i_r0_lock;
    assign w_sel_we    = r_owner_id ? i_r1_we    : i_r0_we;
    assign w_sel_addr  = r_owner_id ? i_r1_addr  : i_r0_addr;
    assign w_sel_wdata = r_owner_id ? i_r1_wdata : i_r0_wdata;

    // Data reads return the synchronised pins, not the output register.
    assign w_rd_val = (w_sel_addr[0] == ADDR_DATA) ? w_sync[w_sel_addr[1]]
                                                   : r_oe[w_sel_addr[1]];

    // On a tie the requester that was not granted last wins; otherwise the
    // single active requester is chosen.
    assign w_any_req  = i_r0_req | i_r1_req;
    assign w_grant_id = (i_r0_req & i_r1_req) ? ~r_last_grant : i_r1_req;

    // ------------------------------------------------------------------
    // Arbiter FSM, register file and watchdog
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_owner_vld  <= 1'b0;
            r_owner_id   <= 1'b0;
            r_last_grant <= 1'b1;
            r_cnt        <= '0;
            r_lock_err   <= 1'b0;
            r_ack        <= 2'b00;
            r_rdata[0]   <= '0;
            r_rdata[1]   <= '0;
            r_out[0]     <= '0;
            r_out[1]     <= '0;
            r_oe[0]      <= '0;
            r_oe[1]      <= '0;
        end else begin
            // Ack, rdata and lock_err are single-cycle by construction.
            r_ack      <= 2'b00;
            r_rdata[0] <= '0;
            r_rdata[1] <= '0;
            r_lock_err <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_owner_vld <= 1'b1;
                        r_owner_id  <= w_grant_id;
                        r_state     <= ST_SERVE;
                    end
                end

                ST_SERVE: begin
                    if (w_sel_we) begin
                        if (w_sel_addr[0] == ADDR_DIR)
                            r_oe[w_sel_addr[1]]  <= w_sel_wdata;
                        else
                            r_out[w_sel_addr[1]] <= w_sel_wdata;
                    end else begin
                        r_rdata[r_owner_id] <= w_rd_val;
                    end
                    r_ack[r_owner_id] <= 1'b1;
                    r_state           <= ST_ACK;
                end

                ST_ACK: begin
                    r_last_grant <= r_owner_id;
                    r_cnt        <= '0;
                    if (w_sel_lock) begin
                        r_state <= ST_HOLD;
                    end else begin
                        r_owner_vld <= 1'b0;
                        r_owner_id  <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end

                ST_HOLD: begin
                    // A pending owner request beats a dropped lock; the lock
                    // is looked at again in ACK.
                    if (w_sel_req) begin
                        r_cnt   <= '0;
                        r_state <= ST_SERVE;
                    end else if (!w_sel_lock) begin
                        r_owner_vld <= 1'b0;
                        r_owner_id  <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_owner_vld <= 1'b0;
                        r_owner_id  <= 1'b0;
                        r_lock_err  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_r0_ack    = r_ack[0];
    assign o_r1_ack    = r_ack[1];
    assign o_r0_rdata  = r_rdata[0];
    assign o_r1_rdata  = r_rdata[1];
    assign o_gpio0_out = r_out[HDR_0];
    assign o_gpio0_oe  = r_oe[HDR_0];
    assign o_gpio1_out = r_out[HDR_1];
    assign o_gpio1_oe  = r_oe[HDR_1];
    assign o_owner     = {r_owner_vld, r_owner_id};
    assign o_lock_err  = r_lock_err;

endmodule : gpio_header_arbiter
`default_nettype wire
